// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and defaults for the data-RAM arbiter.
//               Arbiter states, default parameter values and a helper
//               that sizes the debug starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  // ARB_CPU   : CPU has priority, DBG gets idle cycles.
  // ARB_FORCE : single cycle in which a starved DBG request is forced in.
  typedef enum logic [0:0] {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STAT_W_DEF     = 16;

  // The counter must be able to hold STARVE_MAX itself (it passes the
  // trigger value on the cycle it requests the forced grant).
  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_stats.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_stats
// Description : Arbiter activity counters. Only built when the
//               DMEM_ARB_STATS_EN macro is defined; otherwise this file
//               contributes no module.
// Ports       : clk, rst (async, active-low)
//               cpu_acc    - CPU owned the RAM and accessed it this cycle
//               dbg_gnt    - DBG access performed this cycle
//               cpu_stall  - CPU was stalled this cycle
//               stat_cpu / stat_dbg / stat_stall - wrapping counters
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DMEM_ARB_STATS_EN
module dmem_arb_stats
  import dmem_arb_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_acc,
  input  logic              dbg_gnt,
  input  logic              cpu_stall,
  output logic [STAT_W-1:0] stat_cpu,
  output logic [STAT_W-1:0] stat_dbg,
  output logic [STAT_W-1:0] stat_stall
);

  logic [STAT_W-1:0] r_stat_cpu;
  logic [STAT_W-1:0] r_stat_dbg;
  logic [STAT_W-1:0] r_stat_stall;

  // Counters wrap naturally at 2^STAT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_cpu   <= '0;
      r_stat_dbg   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (cpu_acc)   r_stat_cpu   <= r_stat_cpu   + STAT_W'(1);
      if (dbg_gnt)   r_stat_dbg   <= r_stat_dbg   + STAT_W'(1);
      if (cpu_stall) r_stat_stall <= r_stat_stall + STAT_W'(1);
    end
  end

  assign stat_cpu   = r_stat_cpu;
  assign stat_dbg   = r_stat_dbg;
  assign stat_stall = r_stat_stall;

endmodule
`endif
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one data RAM (combinational read, separate read and
//               write address ports) between the CPU data port and a
//               debug/loader port. The CPU has priority; DBG uses CPU-idle
//               cycles. After STARVE_MAX consecutive denied DBG cycles the
//               DBG access is forced in for one cycle and the CPU stalls.
// Config      : `define DMEM_ARB_STATS_EN to build the statistics counters;
//               without it stat_* are tied to zero.
// Ports       : clk, rst (async, active-low)
//               cpu_re/cpu_we/cpu_raddr/cpu_waddr/cpu_wdata - CPU request
//               cpu_rdata  - RAM read data while the CPU owns the RAM, else 0
//               cpu_stall  - CPU must hold its pipeline this cycle
//               dbg_req/dbg_we/dbg_addr/dbg_wdata - DBG request (level)
//               dbg_gnt    - DBG access performed this cycle
//               dbg_rdata/dbg_rvalid - registered DBG read return
//               mem_re/mem_we/mem_raddr/mem_waddr/mem_wdata - to RAM
//               mem_rdata  - from RAM
//               stat_cpu/stat_dbg/stat_stall - statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int STAT_W     = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_raddr,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // Debug / loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  // RAM port
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Statistics
  output logic [STAT_W-1:0] stat_cpu,
  output logic [STAT_W-1:0] stat_dbg,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int                 c_CNT_W   = starve_cnt_w(STARVE_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_LIM = c_CNT_W'(STARVE_MAX - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT = '1;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [c_CNT_W-1:0] r_starve_cnt;
  logic [c_CNT_W-1:0] w_starve_nxt;

  logic               w_cpu_act;
  logic               w_dbg_own;
  logic               w_stall;

  logic [DATA_W-1:0]  r_dbg_rdata;
  logic               r_dbg_rvalid;

  assign w_cpu_act = cpu_re | cpu_we;

  // --------------------------------------------------------------------------
  // Arbitration FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ARB_CPU;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration FSM: next state, ownership and stall
  // The starve counter clears on every cycle that is not a denied DBG
  // request, so only an unbroken run of denials can trigger a forced grant.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = ARB_CPU;
    w_starve_nxt = '0;
    w_dbg_own    = 1'b0;
    w_stall      = 1'b0;

    case (r_state)
      ARB_CPU: begin
        if (w_cpu_act) begin
          if (dbg_req) begin
            w_starve_nxt = (r_starve_cnt == c_CNT_SAT) ? r_starve_cnt
                                                       : r_starve_cnt + 1'b1;
            // This cycle is the STARVE_MAX-th denial: force DBG in next.
            if (r_starve_cnt >= c_CNT_LIM) begin
              w_state_nxt = ARB_FORCE;
            end
          end
        end else if (dbg_req) begin
          w_dbg_own = 1'b1;
        end
      end

      ARB_FORCE: begin
        // If DBG withdrew its request the CPU simply keeps the RAM.
        if (dbg_req) begin
          w_dbg_own = 1'b1;
          w_stall   = w_cpu_act;
        end
      end

      default: begin
        w_state_nxt = ARB_CPU;
      end
    endcase

    // Keep grant and stall quiet while reset is held, whatever the state.
    if (!rst) begin
      w_dbg_own = 1'b0;
      w_stall   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // RAM port mux: the owner drives the RAM with zero added latency.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_re    = cpu_re;
    mem_we    = cpu_we;
    mem_raddr = cpu_raddr;
    mem_waddr = cpu_waddr;
    mem_wdata = cpu_wdata;

    if (w_dbg_own) begin
      mem_re    = ~dbg_we;
      mem_we    = dbg_we;
      mem_raddr = dbg_addr;
      mem_waddr = dbg_addr;
      mem_wdata = dbg_wdata;
    end

    if (!rst) begin
      mem_re = 1'b0;
      mem_we = 1'b0;
    end
  end

  assign cpu_rdata = w_dbg_own ? '0 : mem_rdata;
  assign cpu_stall = w_stall;
  assign dbg_gnt   = w_dbg_own;

  // --------------------------------------------------------------------------
  // DBG read return: captured at the end of the granted cycle, so rvalid
  // pulses in the following cycle. dbg_rdata holds until the next read.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_dbg_rvalid <= w_dbg_own & ~dbg_we;
      if (w_dbg_own && !dbg_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef DMEM_ARB_STATS_EN
  logic w_cpu_acc;

  // A CPU access counts only when it actually reached the RAM.
  assign w_cpu_acc = w_cpu_act & ~w_dbg_own;

  dmem_arb_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .cpu_acc    (w_cpu_acc),
    .dbg_gnt    (w_dbg_own),
    .cpu_stall  (w_stall),
    .stat_cpu   (stat_cpu),
    .stat_dbg   (stat_dbg),
    .stat_stall (stat_stall)
  );
`else
  assign stat_cpu   = '0;
  assign stat_dbg   = '0;
  assign stat_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter (STARVE_MAX = 4).
//               Directed scenarios followed by randomized traffic checked
//               against a cycle-level reference model. A 16-word RAM with
//               combinational read sits on the mem_* port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int STAT_W     = 16;
  localparam int N_RAND     = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_re, cpu_we;
  logic [ADDR_W-1:0] cpu_raddr, cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [STAT_W-1:0] stat_cpu, stat_dbg, stat_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_raddr(cpu_raddr), .cpu_waddr(cpu_waddr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_cpu(stat_cpu), .stat_dbg(stat_dbg), .stat_stall(stat_stall)
  );

  // 16-word RAM, combinational read, write on the clock edge.
  logic [DATA_W-1:0] ram [0:15];
  always @(posedge clk) begin
    if (mem_we && mem_waddr[ADDR_W-1:4] == '0) ram[mem_waddr[3:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_raddr[ADDR_W-1:4] == '0) ? ram[mem_raddr[3:0]] : ~mem_raddr;

  // Expected statistics after the starvation scenario (4 CPU, 1 DBG, 1 stall).
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    cpu_re = 1'b1; dbg_req = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", cpu_stall); end
    n_checks++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b exp 0", dbg_gnt); end
    n_checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got re=%b we=%b exp 0/0", mem_re, mem_we); end
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 0", dbg_rvalid); end
    n_checks++; if (dbg_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", dbg_rdata); end
    n_checks++; if (stat_cpu !== '0 || stat_dbg !== '0 || stat_stall !== '0) begin
      n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d exp 0/0/0", stat_cpu, stat_dbg, stat_stall);
    end
    // Released into ARB_CPU: active CPU wins, nobody stalls.
    rst = 1'b1;
    #1;
    n_checks++; if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_state_cpu: got gnt=%b stall=%b exp 0/0", dbg_gnt, cpu_stall);
    end
    n_checks++; if (mem_re !== 1'b1) begin n_fail++; $display("FAIL reset_release_re: got %b exp 1", mem_re); end
    tick();
    idle_inputs();
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_dbg_write();
    idle_inputs();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd12; dbg_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL dbgwr_gnt: got %b exp 1", dbg_gnt); end
    n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 32'd12 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL dbgwr_mem: got we=%b a=%0d d=%h exp 1/12/deadbeef", mem_we, mem_waddr, mem_wdata);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (ram[12] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dbgwr_ram: got %h exp deadbeef", ram[12]); end
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbgwr_rvalid: got %b exp 0", dbg_rvalid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_cpu_priority();
    idle_inputs();
    cpu_we = 1'b1; cpu_waddr = 32'd12; cpu_wdata = 32'h000D0000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd12;
    #1;
    n_checks++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL prio_gnt_busy: got %b exp 0", dbg_gnt); end
    n_checks++; if (mem_we !== 1'b1 || mem_waddr !== 32'd12 || mem_wdata !== 32'h000D0000) begin
      n_fail++; $display("FAIL prio_cpu_wr: got we=%b a=%0d d=%h exp 1/12/000d0000", mem_we, mem_waddr, mem_wdata);
    end
    tick();
    cpu_we = 1'b0;
    #1;
    n_checks++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL prio_gnt_idle: got %b exp 1", dbg_gnt); end
    n_checks++; if (mem_re !== 1'b1 || mem_raddr !== 32'd12) begin
      n_fail++; $display("FAIL prio_dbg_rd: got re=%b a=%0d exp 1/12", mem_re, mem_raddr);
    end
    tick();
    dbg_req = 1'b0;
    #1;
    n_checks++; if (dbg_rvalid !== 1'b1) begin n_fail++; $display("FAIL prio_rvalid: got %b exp 1", dbg_rvalid); end
    n_checks++; if (dbg_rdata !== 32'h000D0000) begin n_fail++; $display("FAIL prio_rdata: got %h exp 000d0000", dbg_rdata); end
    tick();
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL prio_rvalid_pulse: got %b exp 0", dbg_rvalid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_starvation();
    do_reset();
    cpu_re = 1'b1; cpu_raddr = 32'd12;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd12;
    for (int c = 1; c <= STARVE_MAX; c++) begin
      #1;
      n_checks++; if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
        n_fail++; $display("FAIL starve_wait_c%0d: got gnt=%b stall=%b exp 0/0", c, dbg_gnt, cpu_stall);
      end
      n_checks++; if (cpu_rdata !== 32'h000D0000) begin
        n_fail++; $display("FAIL starve_cpu_rdata_c%0d: got %h exp 000d0000", c, cpu_rdata);
      end
      tick();
    end
    #1;
    n_checks++; if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL starve_force: got gnt=%b stall=%b exp 1/1", dbg_gnt, cpu_stall);
    end
    n_checks++; if (cpu_rdata !== '0 || mem_re !== 1'b1 || mem_raddr !== 32'd12) begin
      n_fail++; $display("FAIL starve_force_mux: got rdata=%h re=%b a=%0d exp 0/1/12", cpu_rdata, mem_re, mem_raddr);
    end
    tick();
    dbg_req = 1'b0;
    #1;
    n_checks++; if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
      n_fail++; $display("FAIL starve_after: got stall=%b gnt=%b exp 0/0", cpu_stall, dbg_gnt);
    end
    n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h000D0000) begin
      n_fail++; $display("FAIL starve_rdata: got v=%b d=%h exp 1/000d0000", dbg_rvalid, dbg_rdata);
    end
    n_checks++;
    if (stat_cpu !== (STATS_ON ? 16'd4 : 16'd0) || stat_dbg !== (STATS_ON ? 16'd1 : 16'd0) ||
        stat_stall !== (STATS_ON ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL stats_starve: got %0d/%0d/%0d exp %0d/%0d/%0d", stat_cpu, stat_dbg, stat_stall,
                         STATS_ON ? 4 : 0, STATS_ON ? 1 : 0, STATS_ON ? 1 : 0);
    end
    tick();
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_in_force();
    cpu_re = 1'b1; cpu_raddr = 32'd12;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd12;
    repeat (STARVE_MAX) tick();
    #1;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rforce_pre: got stall=%b exp 1", cpu_stall); end
    rst = 1'b0;
    #1;
    n_checks++; if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rforce_in_reset: got stall=%b gnt=%b rv=%b exp 0/0/0", cpu_stall, dbg_gnt, dbg_rvalid);
    end
    tick();
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rforce_no_rvalid: got %b exp 0", dbg_rvalid); end
    rst = 1'b1;
    for (int c = 1; c <= STARVE_MAX; c++) begin
      #1;
      n_checks++; if (dbg_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
        n_fail++; $display("FAIL rforce_rewait_c%0d: got gnt=%b stall=%b exp 0/0", c, dbg_gnt, cpu_stall);
      end
      tick();
    end
    #1;
    n_checks++; if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL rforce_reforce: got gnt=%b stall=%b exp 1/1", dbg_gnt, cpu_stall);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Randomized traffic against a reference model. The model follows the
  // arbitration rules directly: it counts the unbroken run of denied DBG
  // request cycles and forces a grant once that run has reached STARVE_MAX.
  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [DATA_W-1:0] m_mem [16];
    int                m_denied;
    int                e_cpu, e_dbg, e_stall_cnt;
    logic              forced, act, e_own, e_stall, e_re, e_we, e_rv, last_gnt;
    logic [DATA_W-1:0] e_rdata;
    do_reset();
    m_denied = 0; e_cpu = 0; e_dbg = 0; e_stall_cnt = 0; last_gnt = 1'b0;
    for (int i = 0; i < 16 + N_RAND; i++) begin
      if (i < 16) begin
        idle_inputs();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = i; dbg_wdata = $urandom;
      end else begin
        cpu_re = ($urandom_range(0, 7) < 5);
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_raddr = $urandom_range(0, 15);
        cpu_waddr = $urandom_range(0, 15);
        cpu_wdata = $urandom;
        if (!dbg_req || last_gnt || $urandom_range(0, 15) == 0) begin
          dbg_req = $urandom_range(0, 1); dbg_we = $urandom_range(0, 1);
          dbg_addr = $urandom_range(0, 15); dbg_wdata = $urandom;
        end
      end
      #1;
      forced  = (m_denied >= STARVE_MAX);
      act     = cpu_re | cpu_we;
      e_own   = forced ? dbg_req : (dbg_req && !act);
      e_stall = forced && dbg_req && act;
      e_re    = e_own ? !dbg_we : cpu_re;
      e_we    = e_own ? dbg_we : cpu_we;
      n_checks++; if (dbg_gnt !== e_own || cpu_stall !== e_stall) begin
        n_fail++; $display("FAIL rnd_arb[%0d]: got gnt=%b stall=%b exp %b/%b", i, dbg_gnt, cpu_stall, e_own, e_stall);
      end
      n_checks++; if (mem_re !== e_re || mem_we !== e_we) begin
        n_fail++; $display("FAIL rnd_mem_en[%0d]: got re=%b we=%b exp %b/%b", i, mem_re, mem_we, e_re, e_we);
      end
      if (e_own) begin
        n_checks++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rnd_cpu_rdata_blk[%0d]: got %h exp 0", i, cpu_rdata); end
      end else if (i >= 16) begin
        n_checks++; if (cpu_rdata !== m_mem[cpu_raddr[3:0]]) begin
          n_fail++; $display("FAIL rnd_cpu_rdata[%0d]: got %h exp %h", i, cpu_rdata, m_mem[cpu_raddr[3:0]]);
        end
      end
      if (e_we) begin
        n_checks++;
        if (mem_waddr !== (e_own ? dbg_addr : cpu_waddr) || mem_wdata !== (e_own ? dbg_wdata : cpu_wdata)) begin
          n_fail++; $display("FAIL rnd_wr[%0d]: got a=%0d d=%h exp a=%0d d=%h", i, mem_waddr, mem_wdata,
                             e_own ? dbg_addr : cpu_waddr, e_own ? dbg_wdata : cpu_wdata);
        end
      end
      // Model update for the clock edge.
      e_rv    = e_own && !dbg_we;
      e_rdata = m_mem[dbg_addr[3:0]];
      if (e_own && dbg_we)       m_mem[dbg_addr[3:0]]  = dbg_wdata;
      else if (!e_own && cpu_we) m_mem[cpu_waddr[3:0]] = cpu_wdata;
      if (act && !e_own) e_cpu++;
      if (e_own)         e_dbg++;
      if (e_stall)       e_stall_cnt++;
      if (forced)                m_denied = 0;
      else if (dbg_req && act)   m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : m_denied;
      else                       m_denied = 0;
      last_gnt = e_own;
      tick();
      n_checks++; if (dbg_rvalid !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", i, dbg_rvalid, e_rv); end
      if (e_rv) begin
        n_checks++; if (dbg_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, dbg_rdata, e_rdata); end
      end
    end
    n_checks++;
    if (stat_cpu !== (STATS_ON ? STAT_W'(e_cpu) : '0) || stat_dbg !== (STATS_ON ? STAT_W'(e_dbg) : '0) ||
        stat_stall !== (STATS_ON ? STAT_W'(e_stall_cnt) : '0)) begin
      n_fail++; $display("FAIL rnd_stats: got %0d/%0d/%0d exp %0d/%0d/%0d (stats_on=%b)", stat_cpu, stat_dbg,
                         stat_stall, e_cpu, e_dbg, e_stall_cnt, STATS_ON);
    end
    idle_inputs();
    tick();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    idle_inputs();
    test_reset();
    test_dbg_write();
    test_cpu_priority();
    test_starvation();
    test_reset_in_force();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, exp finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
